blit_inhibit: RTL and testbench
===============================

Name: blit_inhibit

Overview:
- Write-inhibit generator for the Tom blitter data path.
- Registers pattern/destination/Z comparisons for each phrase and produces `nowrite` (whole-write inhibit) and per-pixel byte inhibits.
- Sits directly upstream of the blitter stop/collision logic: `nowrite` from this block, qualified by `dwrite_1`, is that stage's collision event.
- GPU programs the compare enables through a command-load strobe.

Parameters:
- PIXW, 16, pixel width in bits (fixed 16bpp compare path)
- NPIX, 4, pixels per 64-bit phrase
- ZW, 16, Z value width

Ports:
- clk_0  in  1  system clock
- xreset_n  in  1  synchronous, active-low reset, sampled on rising clk_0
- gpu_din  in  32  GPU write data, bit 0 first
- cmdld  in  1  load compare-control register from gpu_din
- cmp_valid  in  1  srcd/dstd/patd/srcz/dstz valid this cycle
- phrase_mode  in  1  1 = phrase write, 0 = pixel write
- pixidx  in  2  active pixel lane in pixel mode
- patd  in  64  pattern data
- dstd  in  64  destination data
- srcz  in  64  source Z, 4 × 16
- dstz  in  64  destination Z, 4 × 16
- dwrite_1  in  1  data write cycle strobe (same cycle as outputs)
- nowrite  out  1  inhibit current data write
- dbinh  out  8  byte inhibit, 2 bits per pixel lane
- cmpstat  out  3  latched control bits {zmode[1:0], dcompen} for status read

Behaviour:
- Control register, loaded on the cmdld cycle:
  - dcompen = gpu_din[0]
  - zmode[1:0] = gpu_din[2:1]
  - Encoding: 00 = Z off, 01 = inhibit if srcz < dstz, 10 = inhibit if srcz == dstz, 11 = inhibit if srcz > dstz.
  - Z compares are unsigned 16-bit.
  - Reset value 0.
- Per-lane inhibit for lane i:
  - inh[i] = (dcompen & patd lane == dstd lane) | Z condition on srcz/dstz lane.
- Stage 1, on cmp_valid: inh[3:0], phrase_mode and pixidx are registered.
  - Latency is 1 cycle: data presented at cycle N drives nowrite/dbinh at N+1, aligned with dwrite_1.
  - Without cmp_valid, registered inhibit clears to 0 next cycle; there are no stale inhibits.
- Output decode:
  - Phrase mode: dbinh[2i+1:2i] = {inh[i],inh[i]}; nowrite = AND of inh[3:0] (write fully suppressed only if every lane is inhibited).
  - Pixel mode: nowrite = inh[pixidx]; dbinh = 8'hFF when nowrite, else 0.
- cmdld and cmp_valid in the same cycle: the compare uses the OLD control value; the new value applies from the next cycle.
- Reset (synchronous, has priority over every load):
  - Control register, stage registers, nowrite, dbinh and cmpstat go to 0.
  - Reset mid-operation discards the in-flight phrase; the first cmp_valid after reset release yields outputs one cycle later.
- State, two modes:
  - IDLE: stage register empty.
  - HOLD: stage register valid.
  - IDLE→HOLD on cmp_valid; HOLD→HOLD on cmp_valid; HOLD→IDLE otherwise.
- nowrite is combinational from registered state only; no input→output combinational path.

Optional Feature:
- Macro: BLIT_INHIBIT_COLLCNT_EN.
- When defined:
  - Adds input collclr (1) and output collcnt (16).
  - collcnt increments on each cycle with nowrite & dwrite_1.
  - Saturates at 16'hFFFF.
  - Cleared by collclr or reset; collclr beats a simultaneous increment.
- When undefined: ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (blit_pkg):
  - ZMODE encodings (ZM_OFF, ZM_LT, ZM_EQ, ZM_GT)
  - PIXW/NPIX/ZW constants
  - Lane slice helper constants
- Sub-module: blit_lanecmp, one instance per lane. Inputs are pattern/dest/srcz/dstz slices plus control; output is a 1-bit inhibit. Instantiate NPIX times.

Test Plan:
- Reset load: cmdld with gpu_din=0x7 while xreset_n=0 → after release cmpstat=0; nowrite=0 and dbinh=0 during reset and for all cycles until the first cmp_valid after release.
- Pattern inhibit, pixel mode:
  - Setup: dcompen=1, patd=dstd=0x1234_5678_9ABC_DEF0, pixidx=2, cmp_valid.
  - Response: next cycle nowrite=1, dbinh=8'hFF.
  - With dstd lane 2 changed to 0x0000: nowrite=0, dbinh=0.
- Phrase Z partial:
  - Setup: zmode=01, srcz lanes {5,9,5,9}, dstz all 7, phrase_mode=1.
  - Response: dbinh=8'b00110011, nowrite=0.
  - With all srcz=5: nowrite=1, dbinh=8'hFF.
- Simultaneous load/compare: dcompen=0, then cmdld(gpu_din=1) and cmp_valid with patd==dstd in the same cycle → nowrite=0 next cycle; repeat compare one cycle later → nowrite=1.
- Mid-op reset: cmp_valid with a full inhibit, then xreset_n=0 the following cycle → nowrite=0 on the cycle after reset is sampled, control register cleared.
- Counter (BLIT_INHIBIT_COLLCNT_EN):
  - Preload to 0xFFFE, then 3 cycles of nowrite & dwrite_1 → 0xFFFF, holds.
  - collclr together with an increment → 0.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and constants for the blitter write-inhibit path.
package blit_pkg;

  localparam int unsigned PIXW          = 16;
  localparam int unsigned NPIX          = 4;
  localparam int unsigned ZW            = 16;
  localparam int unsigned PHRASE_W      = PIXW * NPIX;
  localparam int unsigned ZPHRASE_W     = ZW * NPIX;
  localparam int unsigned BYTES_PER_PIX = PIXW / 8;
  localparam int unsigned DBINH_W       = BYTES_PER_PIX * NPIX;
  localparam int unsigned PIXIDX_W      = $clog2(NPIX);
  localparam int unsigned GPU_W         = 32;
  localparam int unsigned CTRL_W        = 3;
  localparam int unsigned CNT_W         = 16;

  typedef enum logic [1:0] {
    ZM_OFF = 2'b00,
    ZM_LT  = 2'b01,
    ZM_EQ  = 2'b10,
    ZM_GT  = 2'b11
  } zmode_e;

  // Bit layout matches gpu_din[2:0] and the cmpstat status field.
  typedef struct packed {
    zmode_e zmode;
    logic   dcompen;
  } ctrl_t;

endpackage

// File: rtl/blit_inhibit_if.sv
// Compare/data bus between the blitter data path and the inhibit block.
// Optional collision counter pins exist only with BLIT_INHIBIT_COLLCNT_EN.
interface blit_inhibit_if
  import blit_pkg::*;
();
  logic [GPU_W-1:0]     gpu_din;
  logic                 cmdld;
  logic                 cmp_valid;
  logic                 phrase_mode;
  logic [PIXIDX_W-1:0]  pixidx;
  logic [PHRASE_W-1:0]  patd;
  logic [PHRASE_W-1:0]  dstd;
  logic [ZPHRASE_W-1:0] srcz;
  logic [ZPHRASE_W-1:0] dstz;
  logic                 dwrite_1;
  logic                 nowrite;
  logic [DBINH_W-1:0]   dbinh;
  logic [CTRL_W-1:0]    cmpstat;
`ifdef BLIT_INHIBIT_COLLCNT_EN
  logic                 collclr;
  logic [CNT_W-1:0]     collcnt;

  modport master (
    output gpu_din, cmdld, cmp_valid, phrase_mode, pixidx,
           patd, dstd, srcz, dstz, dwrite_1, collclr,
    input  nowrite, dbinh, cmpstat, collcnt
  );
  modport slave (
    input  gpu_din, cmdld, cmp_valid, phrase_mode, pixidx,
           patd, dstd, srcz, dstz, dwrite_1, collclr,
    output nowrite, dbinh, cmpstat, collcnt
  );
`else
  modport master (
    output gpu_din, cmdld, cmp_valid, phrase_mode, pixidx,
           patd, dstd, srcz, dstz, dwrite_1,
    input  nowrite, dbinh, cmpstat
  );
  modport slave (
    input  gpu_din, cmdld, cmp_valid, phrase_mode, pixidx,
           patd, dstd, srcz, dstz, dwrite_1,
    output nowrite, dbinh, cmpstat
  );
`endif
endinterface

// File: rtl/blit_lanecmp.sv
// Single-lane inhibit: pattern/destination match and unsigned Z test.
module blit_lanecmp
  import blit_pkg::*;
(
  input  logic [PIXW-1:0] pat_i,
  input  logic [PIXW-1:0] dst_i,
  input  logic [ZW-1:0]   srcz_i,
  input  logic [ZW-1:0]   dstz_i,
  input  logic            dcompen_i,
  input  zmode_e          zmode_i,
  output logic            inh_c_o
);
  logic z_inh;

  always_comb begin
    z_inh = 1'b0;
    case (zmode_i)
      ZM_LT:   z_inh = (srcz_i < dstz_i);
      ZM_EQ:   z_inh = (srcz_i == dstz_i);
      ZM_GT:   z_inh = (srcz_i > dstz_i);
      default: z_inh = 1'b0;
    endcase
    inh_c_o = (dcompen_i && (pat_i == dst_i)) || z_inh;
  end

endmodule

// File: rtl/blit_inhibit.sv
// Write-inhibit generator: registers per-lane compares, decodes nowrite/dbinh.
// Optional saturating collision counter under BLIT_INHIBIT_COLLCNT_EN.
module blit_inhibit
  import blit_pkg::*;
(
  input logic           clk_0,
  input logic           xreset_n,
  blit_inhibit_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [NPIX-1:0]       inh_lane_c;
  logic [NPIX-1:0]       inh_q, inh_d;
  logic                  phrase_q, phrase_d;
  logic [PIXIDX_W-1:0]   pixidx_q, pixidx_d;
  logic                  nowrite_c;
  logic [DBINH_W-1:0]    dbinh_c;
  logic [GPU_W-CTRL_W-1:0] unused_gpu_hi;

  assign unused_gpu_hi = bus.gpu_din[GPU_W-1:CTRL_W];

  for (genvar i = 0; i < NPIX; i++) begin : g_lane
    blit_lanecmp u_lanecmp (
      .pat_i     (bus.patd[i*PIXW +: PIXW]),
      .dst_i     (bus.dstd[i*PIXW +: PIXW]),
      .srcz_i    (bus.srcz[i*ZW +: ZW]),
      .dstz_i    (bus.dstz[i*ZW +: ZW]),
      .dcompen_i (ctrl_q.dcompen),
      .zmode_i   (ctrl_q.zmode),
      .inh_c_o   (inh_lane_c[i])
    );
  end

  always_ff @(posedge clk_0) begin
    if (!xreset_n) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      inh_q    <= '0;
      phrase_q <= 1'b0;
      pixidx_q <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      inh_q    <= inh_d;
      phrase_q <= phrase_d;
      pixidx_q <= pixidx_d;
    end
  end

  // Lanes compare against ctrl_q, so a same-cycle cmdld only affects later phrases.
  always_comb begin
    state_d   = IDLE;
    ctrl_d    = ctrl_q;
    inh_d     = '0;
    phrase_d  = 1'b0;
    pixidx_d  = '0;
    nowrite_c = 1'b0;
    dbinh_c   = '0;

    if (bus.cmdld) begin
      ctrl_d = ctrl_t'(bus.gpu_din[CTRL_W-1:0]);
    end

    if (bus.cmp_valid) begin
      state_d  = HOLD;
      inh_d    = inh_lane_c;
      phrase_d = bus.phrase_mode;
      pixidx_d = bus.pixidx;
    end

    if (state_q == HOLD) begin
      if (phrase_q) begin
        nowrite_c = &inh_q;
        for (int i = 0; i < NPIX; i++) begin
          dbinh_c[i*BYTES_PER_PIX +: BYTES_PER_PIX] = {BYTES_PER_PIX{inh_q[i]}};
        end
      end else begin
        nowrite_c = inh_q[pixidx_q];
        dbinh_c   = {DBINH_W{nowrite_c}};
      end
    end
  end

  assign bus.nowrite = nowrite_c;
  assign bus.dbinh   = dbinh_c;
  assign bus.cmpstat = ctrl_q;

`ifdef BLIT_INHIBIT_COLLCNT_EN
  logic [CNT_W-1:0] collcnt_q, collcnt_d;

  // Counts qualified collisions; clear wins over increment, saturates at max.
  always_comb begin
    collcnt_d = collcnt_q;
    if (bus.collclr) begin
      collcnt_d = '0;
    end else if (nowrite_c && bus.dwrite_1 && (collcnt_q != {CNT_W{1'b1}})) begin
      collcnt_d = collcnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_0) begin
    if (!xreset_n) begin
      collcnt_q <= '0;
    end else begin
      collcnt_q <= collcnt_d;
    end
  end

  assign bus.collcnt = collcnt_q;
`else
  logic unused_dwrite;
  assign unused_dwrite = bus.dwrite_1;
`endif

endmodule

// File: tb/tb_blit_inhibit.sv
// Directed bench for blit_inhibit with a lane-level behavioural reference model.
module tb_blit_inhibit;
  logic clk_0 = 1'b0;
  logic xreset_n;
  always #5 clk_0 = ~clk_0;

  blit_inhibit_if bif ();
  blit_inhibit dut (.clk_0(clk_0), .xreset_n(xreset_n), .bus(bif));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit         m_dcompen = 1'b0;
  bit [1:0]   m_zmode = 2'b00;
  logic       exp_nowrite = 1'b0;
  logic [7:0] exp_dbinh = 8'h00;
  logic [2:0] exp_cmpstat = 3'b000;
  logic [15:0] exp_collcnt = 16'h0000;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: lane-by-lane rule evaluation, then write-mode decode.
  function automatic logic [8:0] model_out(bit dc, bit [1:0] zm, logic valid, logic phrase,
                                           logic [1:0] pix, logic [63:0] pd, logic [63:0] dd,
                                           logic [63:0] sz, logic [63:0] dz);
    logic [3:0] inh;
    logic [7:0] db;
    logic nw;
    int unsigned p, d, s, z;
    for (int i = 0; i < 4; i++) begin
      p = int'(pd[16*i +: 16]); d = int'(dd[16*i +: 16]);
      s = int'(sz[16*i +: 16]); z = int'(dz[16*i +: 16]);
      inh[i] = valid && ((dc && p == d) || (zm == 2'd1 && s < z) ||
                         (zm == 2'd2 && s == z) || (zm == 2'd3 && s > z));
    end
    if (phrase) begin
      nw = (inh == 4'hF);
      for (int i = 0; i < 4; i++) db[2*i +: 2] = inh[i] ? 2'b11 : 2'b00;
    end else begin
      nw = inh[pix];
      db = nw ? 8'hFF : 8'h00;
    end
    return {nw, db};
  endfunction

  always @(posedge clk_0) begin
    if (!xreset_n) begin
      m_dcompen <= 1'b0; m_zmode <= 2'b00;
      exp_nowrite <= 1'b0; exp_dbinh <= 8'h00; exp_cmpstat <= 3'b000;
    end else begin
      {exp_nowrite, exp_dbinh} <= model_out(m_dcompen, m_zmode, bif.cmp_valid, bif.phrase_mode,
                                            bif.pixidx, bif.patd, bif.dstd, bif.srcz, bif.dstz);
      if (bif.cmdld) begin
        m_dcompen <= bif.gpu_din[0];
        m_zmode <= bif.gpu_din[2:1];
        exp_cmpstat <= bif.gpu_din[2:0];
      end
    end
`ifdef BLIT_INHIBIT_COLLCNT_EN
    if (!xreset_n || bif.collclr) exp_collcnt <= 16'h0000;
    else if (exp_nowrite && bif.dwrite_1 && exp_collcnt != 16'hFFFF) exp_collcnt <= exp_collcnt + 16'd1;
`endif
  end

  always @(negedge clk_0) begin
    if (chk_en) begin
      check("nowrite", 32'(bif.nowrite), 32'(exp_nowrite));
      check("dbinh", 32'(bif.dbinh), 32'(exp_dbinh));
      check("cmpstat", 32'(bif.cmpstat), 32'(exp_cmpstat));
`ifdef BLIT_INHIBIT_COLLCNT_EN
      check("collcnt", 32'(bif.collcnt), 32'(exp_collcnt));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk_0);
    #1;
  endtask

  task automatic expect_out(string name, logic nw, logic [7:0] db);
    check({name, " nowrite"}, 32'(bif.nowrite), 32'(nw));
    check({name, " dbinh"}, 32'(bif.dbinh), 32'(db));
    check({name, " model"}, 32'({exp_nowrite, exp_dbinh}), 32'({nw, db}));
  endtask

  task automatic load(logic [31:0] val);
    bif.cmdld = 1'b1; bif.gpu_din = val; bif.cmp_valid = 1'b0;
    cyc();
    bif.cmdld = 1'b0;
  endtask

  task automatic drive(logic phrase, logic [1:0] pix, logic [63:0] pd, logic [63:0] dd,
                       logic [63:0] sz, logic [63:0] dz);
    bif.cmp_valid = 1'b1; bif.phrase_mode = phrase; bif.pixidx = pix;
    bif.patd = pd; bif.dstd = dd; bif.srcz = sz; bif.dstz = dz;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  localparam logic [63:0] PD = 64'h1234_5678_9ABC_DEF0;

  initial begin
    xreset_n = 1'b0;
    bif.gpu_din = 32'h7; bif.cmdld = 1'b1; bif.dwrite_1 = 1'b0;
    bif.cmp_valid = 1'b0; bif.phrase_mode = 1'b0; bif.pixidx = 2'd0;
    bif.patd = '0; bif.dstd = '0; bif.srcz = '0; bif.dstz = '0;
`ifdef BLIT_INHIBIT_COLLCNT_EN
    bif.collclr = 1'b0;
`endif
    // Reset while loading and presenting a matching phrase.
    drive(1'b1, 2'd0, PD, PD, 64'h1, 64'h1);
    cyc();
    chk_en = 1'b1;
    cyc(); cyc();
    check("reset cmpstat", 32'(bif.cmpstat), 32'h0);
    expect_out("in reset", 1'b0, 8'h00);
    xreset_n = 1'b1; bif.cmdld = 1'b0; bif.cmp_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("post-reset cmpstat", 32'(bif.cmpstat), 32'h0);
    expect_out("post-reset idle", 1'b0, 8'h00);

    // Pattern inhibit, pixel mode.
    load(32'h1);
    drive(1'b0, 2'd2, PD, PD, '0, 64'h1);
    cyc();
    expect_out("pix match", 1'b1, 8'hFF);
    drive(1'b0, 2'd2, PD, 64'h1234_0000_9ABC_DEF0, '0, 64'h1);
    cyc();
    expect_out("pix lane2 diff", 1'b0, 8'h00);
    drive(1'b0, 2'd3, PD, 64'h1234_0000_9ABC_DEF0, '0, 64'h1);
    cyc();
    expect_out("pix lane3 match", 1'b1, 8'hFF);
    bif.cmp_valid = 1'b0;
    cyc();
    expect_out("no stale", 1'b0, 8'h00);

    // Phrase-mode Z compares.
    load(32'h2);
    drive(1'b1, 2'd0, PD, ~PD, 64'h0009_0005_0009_0005, 64'h0007_0007_0007_0007);
    cyc();
    expect_out("z lt partial", 1'b0, 8'h33);
    drive(1'b1, 2'd0, PD, ~PD, 64'h0005_0005_0005_0005, 64'h0007_0007_0007_0007);
    cyc();
    expect_out("z lt full", 1'b1, 8'hFF);
    drive(1'b1, 2'd0, PD, ~PD, 64'h0000_FFFF_0000_FFFF, 64'hFFFF_0001_FFFF_0001);
    cyc();
    expect_out("z lt unsigned", 1'b0, 8'hCC);
    load(32'h6);
    drive(1'b1, 2'd0, PD, ~PD, 64'h0009_0005_0009_0005, 64'h0007_0007_0007_0007);
    cyc();
    expect_out("z gt partial", 1'b0, 8'hCC);
    load(32'h4);
    drive(1'b0, 2'd1, PD, ~PD, 64'h0001_0002_0003_0004, 64'h0000_0000_0003_0000);
    cyc();
    expect_out("z eq pix1", 1'b1, 8'hFF);
    drive(1'b0, 2'd0, PD, ~PD, 64'h0001_0002_0003_0004, 64'h0000_0000_0003_0000);
    cyc();
    expect_out("z eq pix0", 1'b0, 8'h00);

    // cmdld coincident with compare uses the old control value.
    load(32'h0);
    bif.cmdld = 1'b1; bif.gpu_din = 32'h1;
    drive(1'b1, 2'd0, PD, PD, '0, '0);
    cyc();
    bif.cmdld = 1'b0;
    expect_out("same-cycle old ctrl", 1'b0, 8'h00);
    cyc();
    expect_out("new ctrl applied", 1'b1, 8'hFF);
    check("cmpstat dcompen", 32'(bif.cmpstat), 32'h1);

    // Reset the cycle after a full-inhibit compare.
    xreset_n = 1'b0;
    cyc();
    expect_out("mid-op reset", 1'b0, 8'h00);
    check("mid-op cmpstat", 32'(bif.cmpstat), 32'h0);
    xreset_n = 1'b1;
    cyc();
    expect_out("ctrl cleared", 1'b0, 8'h00);

`ifdef BLIT_INHIBIT_COLLCNT_EN
    load(32'h1);
    bif.collclr = 1'b1;
    drive(1'b1, 2'd0, PD, PD, '0, '0);
    cyc();
    bif.collclr = 1'b0; bif.dwrite_1 = 1'b1;
    for (int n = 0; n < 70000 && bif.collcnt != 16'hFFFE; n++) cyc();
    check("collcnt preload", 32'(bif.collcnt), 32'hFFFE);
    cyc(); cyc(); cyc();
    check("collcnt saturate", 32'(bif.collcnt), 32'hFFFF);
    bif.collclr = 1'b1;
    cyc();
    check("collclr wins", 32'(bif.collcnt), 32'h0);
    bif.collclr = 1'b0; bif.dwrite_1 = 1'b0;
`endif
    bif.cmp_valid = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
